// File: rtl/gate_eval_scheduler.sv
// gate_eval_scheduler
// Round-robin scheduler that time-shares one combinational gate evaluator
// (Y = &AND8 & |OR15 & ~NOT) between NUM_REQ requesters. One operand set is
// accepted per transaction, held on eval_* for EVAL_LAT cycles, then eval_y is
// sampled and returned tagged with the requester index.
module gate_eval_scheduler #(
  parameter  int unsigned NUM_REQ  = 4,
  parameter  int unsigned EVAL_LAT = 1,
  parameter  int unsigned CNT_W    = 16,
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*8-1:0]    req_and,
  input  logic [NUM_REQ*15-1:0]   req_or,
  input  logic [NUM_REQ-1:0]      req_not,
  output logic [7:0]              eval_a,
  output logic [14:0]             eval_o,
  output logic                    eval_n,
  input  logic                    eval_y,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_y,
  output logic                    busy,
  output logic [CNT_W-1:0]        done_cnt
);

  localparam int unsigned AND_W  = 8;
  localparam int unsigned OR_W   = 15;
  localparam int unsigned WCNT_W = $clog2(EVAL_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [AND_W-1:0]   eval_a_q, eval_a_d;
  logic [OR_W-1:0]    eval_o_q, eval_o_d;
  logic               eval_n_q, eval_n_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic               rsp_y_q, rsp_y_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;

  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    cand;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [AND_W-1:0]   sel_and;
  logic [OR_W-1:0]    sel_or;
  logic               sel_not;

  // (base + off) mod NUM_REQ for off < NUM_REQ; works for non-power-of-two NUM_REQ
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return ID_W'(sum);
  endfunction

  // Round-robin search: first valid requester starting at ptr
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = wrap_idx(ptr_q, k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // One-hot grant vector and operand selection for the winner
  always_comb begin
    gnt_onehot = '0;
    sel_and    = '0;
    sel_or     = '0;
    sel_not    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gnt_onehot[i] = gnt_found && (gnt_idx == ID_W'(i));
      if (gnt_onehot[i]) begin
        sel_and = req_and[AND_W*i +: AND_W];
        sel_or  = req_or[OR_W*i +: OR_W];
        sel_not = req_not[i];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_found)                state_d = ST_WAIT;
      ST_WAIT: if (wcnt_q == WCNT_W'(1))     state_d = ST_RESP;
      ST_RESP: if (rsp_ready)                state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: accept handshake, operand capture, wait count, response and counters
  always_comb begin
    req_ready   = '0;
    ptr_d       = ptr_q;
    wcnt_d      = wcnt_q;
    eval_a_d    = eval_a_q;
    eval_o_d    = eval_o_q;
    eval_n_d    = eval_n_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    done_cnt_d  = done_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // reset is IDLE, so gate with rst_n to keep req_ready low while reset is held
        req_ready = gnt_onehot & {NUM_REQ{rst_n}};
        if (gnt_found) begin
          eval_a_d = sel_and;
          eval_o_d = sel_or;
          eval_n_d = sel_not;
          rsp_id_d = gnt_idx;
          ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          wcnt_d   = WCNT_W'(EVAL_LAT);
        end
      end
      ST_WAIT: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (wcnt_q == WCNT_W'(1)) begin
          rsp_y_d = eval_y;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          done_cnt_d = done_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    rsp_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      wcnt_q      <= '0;
      eval_a_q    <= '0;
      eval_o_q    <= '0;
      eval_n_q    <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      wcnt_q      <= wcnt_d;
      eval_a_q    <= eval_a_d;
      eval_o_q    <= eval_o_d;
      eval_n_q    <= eval_n_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign eval_a    = eval_a_q;
  assign eval_o    = eval_o_q;
  assign eval_n    = eval_n_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign busy      = busy_q;
  assign done_cnt  = done_cnt_q;

endmodule
